reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_file_rd_port.sv | 42 ++++
 rtl/reg_file.sv | 64 ++++++
 tb/tb_reg_file.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared defaults and types for the reg_file register bank.
package reg_file_pkg;

    localparam int REGISTER_COUNT  = 32;
    localparam int REGISTER_WIDTH  = 32;
    localparam int REG_INDEX_WIDTH = 5;

    typedef logic [REGISTER_WIDTH-1:0] reg_data_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// One combinational read port: index mux with register 0 forced to zero.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the port.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int REGISTER_COUNT  = reg_file_pkg::REGISTER_COUNT,
    parameter int REGISTER_WIDTH  = reg_file_pkg::REGISTER_WIDTH,
    parameter int REG_INDEX_WIDTH = reg_file_pkg::REG_INDEX_WIDTH
) (
    input  logic [REGISTER_COUNT-1:0][REGISTER_WIDTH-1:0] regs,
    input  logic [REG_INDEX_WIDTH-1:0]                    rd_index,
`ifdef REG_FILE_BYPASS_EN
    input  logic                                          rst,
    input  logic                                          wr_en,
    input  logic [REG_INDEX_WIDTH-1:0]                    wr_index,
    input  logic [REGISTER_WIDTH-1:0]                     wr_data,
`endif
    output logic [REGISTER_WIDTH-1:0]                     rd_data
);

    logic [REGISTER_WIDTH-1:0] rd_data_s;

    // Select the addressed register, zero for index 0, forwarded data when bypassing
    always_comb begin
        rd_data_s = {REGISTER_WIDTH{1'b0}};
        if (rd_index == {REG_INDEX_WIDTH{1'b0}}) begin
            rd_data_s = {REGISTER_WIDTH{1'b0}};
        end
`ifdef REG_FILE_BYPASS_EN
        else if (wr_en && !rst && (wr_index != {REG_INDEX_WIDTH{1'b0}}) &&
                 (wr_index == rd_index)) begin
            rd_data_s = wr_data;
        end
`endif
        else begin
            rd_data_s = regs[rd_index];
        end
    end

    assign rd_data = rd_data_s;

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// Two-read, one-write register file with hardwired-zero register 0.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int REGISTER_COUNT  = reg_file_pkg::REGISTER_COUNT,
    parameter int REGISTER_WIDTH  = reg_file_pkg::REGISTER_WIDTH,
    parameter int REG_INDEX_WIDTH = reg_file_pkg::REG_INDEX_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [REG_INDEX_WIDTH-1:0] wr_reg_index,
    input  logic [REGISTER_WIDTH-1:0]  wr_reg_data,
    input  logic [REG_INDEX_WIDTH-1:0] rd_reg_index_1,
    input  logic [REG_INDEX_WIDTH-1:0] rd_reg_index_2,
    output logic [REGISTER_WIDTH-1:0]  reg_data_1,
    output logic [REGISTER_WIDTH-1:0]  reg_data_2
);

    logic [REGISTER_COUNT-1:0][REGISTER_WIDTH-1:0] regs_r;

    // Register storage: reset clears everything and takes priority over writes
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_r <= {(REGISTER_COUNT*REGISTER_WIDTH){1'b0}};
        end else if (wr_en && (wr_reg_index != {REG_INDEX_WIDTH{1'b0}})) begin
            regs_r[wr_reg_index] <= wr_reg_data;
        end
    end

    reg_file_rd_port #(
        .REGISTER_COUNT (REGISTER_COUNT),
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .REG_INDEX_WIDTH(REG_INDEX_WIDTH)
    ) u_rd_port_1 (
        .regs    (regs_r),
        .rd_index(rd_reg_index_1),
`ifdef REG_FILE_BYPASS_EN
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_index(wr_reg_index),
        .wr_data (wr_reg_data),
`endif
        .rd_data (reg_data_1)
    );

    reg_file_rd_port #(
        .REGISTER_COUNT (REGISTER_COUNT),
        .REGISTER_WIDTH (REGISTER_WIDTH),
        .REG_INDEX_WIDTH(REG_INDEX_WIDTH)
    ) u_rd_port_2 (
        .regs    (regs_r),
        .rd_index(rd_reg_index_2),
`ifdef REG_FILE_BYPASS_EN
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_index(wr_reg_index),
        .wr_data (wr_reg_data),
`endif
        .rd_data (reg_data_2)
    );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; expectations follow REG_FILE_BYPASS_EN.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_reg_index;
    logic [31:0] wr_reg_data;
    logic [4:0]  rd_reg_index_1;
    logic [4:0]  rd_reg_index_2;
    logic [31:0] reg_data_1;
    logic [31:0] reg_data_2;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_reg_index  (wr_reg_index),
        .wr_reg_data   (wr_reg_data),
        .rd_reg_index_1(rd_reg_index_1),
        .rd_reg_index_2(rd_reg_index_2),
        .reg_data_1    (reg_data_1),
        .reg_data_2    (reg_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // One-cycle write pulse; returns at the next falling edge
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        wr_en        = 1'b1;
        wr_reg_index = idx;
        wr_reg_data  = data;
        @(negedge clk);
        wr_en        = 1'b0;
    endtask

    task automatic reset_edge();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_edge();
        rd_reg_index_1 = 5'd10;
        rd_reg_index_2 = 5'd15;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rd1: got %h expected %h", reg_data_1, 32'd0);
        end
        n_checks++;
        if (reg_data_2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rd2: got %h expected %h", reg_data_2, 32'd0);
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 32'd1234);
        rd_reg_index_1 = 5'd5;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd1234) begin
            n_fail++;
            $display("FAIL write5_rd1: got %h expected %h", reg_data_1, 32'd1234);
        end
        write_reg(5'd31, 32'hFFFF_FFFF);
        write_reg(5'd1, 32'hA5A5_5A5A);
        rd_reg_index_1 = 5'd31;
        rd_reg_index_2 = 5'd1;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL write31_rd1: got %h expected %h", reg_data_1, 32'hFFFF_FFFF);
        end
        n_checks++;
        if (reg_data_2 !== 32'hA5A5_5A5A) begin
            n_fail++;
            $display("FAIL write1_rd2: got %h expected %h", reg_data_2, 32'hA5A5_5A5A);
        end
        // index change is seen within the same cycle
        #1;
        rd_reg_index_1 = 5'd5;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd1234) begin
            n_fail++;
            $display("FAIL index_track_rd1: got %h expected %h", reg_data_1, 32'd1234);
        end
    endtask

    task automatic test_zero_reg();
        write_reg(5'd0, 32'd2431);
        rd_reg_index_1 = 5'd0;
        rd_reg_index_2 = 5'd0;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_reg_rd1: got %h expected %h", reg_data_1, 32'd0);
        end
        n_checks++;
        if (reg_data_2 !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_reg_rd2: got %h expected %h", reg_data_2, 32'd0);
        end
    endtask

    task automatic test_wr_en_low();
        @(negedge clk);
        wr_en        = 1'b0;
        wr_reg_index = 5'd5;
        wr_reg_data  = 32'd777;
        @(negedge clk);
        rd_reg_index_1 = 5'd5;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd1234) begin
            n_fail++;
            $display("FAIL wr_en_low_rd1: got %h expected %h", reg_data_1, 32'd1234);
        end
    endtask

    task automatic test_dual_port_and_reset();
        rd_reg_index_1 = 5'd5;
        rd_reg_index_2 = 5'd5;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd1234) begin
            n_fail++;
            $display("FAIL dual_same_rd1: got %h expected %h", reg_data_1, 32'd1234);
        end
        n_checks++;
        if (reg_data_2 !== 32'd1234) begin
            n_fail++;
            $display("FAIL dual_same_rd2: got %h expected %h", reg_data_2, 32'd1234);
        end
        reset_edge();
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_rd1: got %h expected %h", reg_data_1, 32'd0);
        end
        n_checks++;
        if (reg_data_2 !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_rd2: got %h expected %h", reg_data_2, 32'd0);
        end
        rd_reg_index_1 = 5'd31;
        rd_reg_index_2 = 5'd1;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_r31: got %h expected %h", reg_data_1, 32'd0);
        end
        n_checks++;
        if (reg_data_2 !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset_r1: got %h expected %h", reg_data_2, 32'd0);
        end
    endtask

    task automatic test_reset_priority();
        write_reg(5'd7, 32'd55);
        rd_reg_index_1 = 5'd7;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd55) begin
            n_fail++;
            $display("FAIL pre_rst_r7: got %h expected %h", reg_data_1, 32'd55);
        end
        @(negedge clk);
        rst          = 1'b1;
        wr_en        = 1'b1;
        wr_reg_index = 5'd7;
        wr_reg_data  = 32'd99;
        @(negedge clk);
        rst   = 1'b0;
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_priority_r7: got %h expected %h", reg_data_1, 32'd0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wr_en        = 1'b1;
        wr_reg_index = 5'd3;
        wr_reg_data  = 32'd11;
        @(negedge clk);
        wr_reg_data  = 32'd22;
        @(negedge clk);
        wr_reg_data  = 32'd33;
        @(negedge clk);
        wr_reg_index = 5'd4;
        wr_reg_data  = 32'h0000_0044;
        @(negedge clk);
        wr_reg_index = 5'd6;
        wr_reg_data  = 32'h6666_0000;
        @(negedge clk);
        wr_en = 1'b0;
        rd_reg_index_1 = 5'd3;
        rd_reg_index_2 = 5'd4;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd33) begin
            n_fail++;
            $display("FAIL last_write_wins_r3: got %h expected %h", reg_data_1, 32'd33);
        end
        n_checks++;
        if (reg_data_2 !== 32'h0000_0044) begin
            n_fail++;
            $display("FAIL b2b_r4: got %h expected %h", reg_data_2, 32'h0000_0044);
        end
        rd_reg_index_2 = 5'd6;
        #1;
        n_checks++;
        if (reg_data_2 !== 32'h6666_0000) begin
            n_fail++;
            $display("FAIL b2b_r6: got %h expected %h", reg_data_2, 32'h6666_0000);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_before;
        write_reg(5'd9, 32'h0000_1111);
`ifdef REG_FILE_BYPASS_EN
        exp_before = 32'hDEAD_BEEF;
`else
        exp_before = 32'h0000_1111;
`endif
        @(negedge clk);
        wr_en          = 1'b1;
        wr_reg_index   = 5'd9;
        wr_reg_data    = 32'hDEAD_BEEF;
        rd_reg_index_1 = 5'd9;
        rd_reg_index_2 = 5'd3;
        #1;
        n_checks++;
        if (reg_data_1 !== exp_before) begin
            n_fail++;
            $display("FAIL bypass_before_edge: got %h expected %h", reg_data_1, exp_before);
        end
        n_checks++;
        if (reg_data_2 !== 32'd33) begin
            n_fail++;
            $display("FAIL bypass_other_port: got %h expected %h", reg_data_2, 32'd33);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (reg_data_1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_after_edge: got %h expected %h", reg_data_1, 32'hDEAD_BEEF);
        end
        // write to index 0 must never be forwarded
        @(negedge clk);
        wr_reg_index   = 5'd0;
        wr_reg_data    = 32'h1234_5678;
        rd_reg_index_1 = 5'd0;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'd0) begin
            n_fail++;
            $display("FAIL bypass_zero_idx: got %h expected %h", reg_data_1, 32'd0);
        end
        @(negedge clk);
        wr_en          = 1'b0;
        rd_reg_index_1 = 5'd9;
        #1;
        n_checks++;
        if (reg_data_1 !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL bypass_hold_r9: got %h expected %h", reg_data_1, 32'hDEAD_BEEF);
        end
    endtask

    initial begin
        rst            = 1'b1;
        wr_en          = 1'b0;
        wr_reg_index   = 5'd0;
        wr_reg_data    = 32'd0;
        rd_reg_index_1 = 5'd0;
        rd_reg_index_2 = 5'd0;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_wr_en_low();
        test_dual_port_and_reset();
        test_reset_priority();
        test_back_to_back();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file
